// File: rtl/simplez_loader_pkg.sv
// Shared definitions for the Simplez serial program loader: FSM encoding and record tags.
// Pure declarations; no timing or flow-control implications of its own.
package simplez_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT_A = 3'd1;
  localparam logic [2:0] ST_WAIT_B = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  localparam logic [3:0] TAG_WORD = 4'h1;
  localparam logic [3:0] TAG_ADDR = 4'h2;
  localparam logic [3:0] TAG_END  = 4'hF;

  typedef struct packed {
    logic [3:0] tag;
    logic [3:0] hi;
  } byte_a_t;

  function automatic logic tag_legal(input logic [3:0] tag);
    return (tag == TAG_WORD) || (tag == TAG_ADDR) || (tag == TAG_END);
  endfunction

  function automatic logic is_busy_state(input logic [2:0] st);
    return (st == ST_WAIT_A) || (st == ST_WAIT_B) || (st == ST_WRITE);
  endfunction

endpackage

// File: rtl/simplez_loader_timeout.sv
// Loadable down-counter guarding the gap between the two bytes of a record.
// expired is combinational on the count (0 = spent); load wins over enable, no backpressure.
module loader_timeout #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/simplez_loader.sv
// Serial byte stream -> Simplez program memory write cycles; wr rises the cycle after byte B.
// No backpressure: every rx_valid strobe is consumed or dropped in the cycle it arrives.
module simplez_loader
  import simplez_loader_pkg::*;
#(
  parameter int unsigned AW      = 9,
  parameter int unsigned DW      = 12,
  parameter int unsigned TIMEOUT = 120000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [AW-1:0] addr,
  output logic          wr,
  output logic [DW-1:0] data_out,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   word_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] COUNT_MAX = (AW + 1)'(1) << AW;

  logic [2:0] state;
  logic [2:0] state_nxt;
  byte_a_t    byte_a;
  logic       take_a;
  logic       tmo_load;
  logic       tmo_expired;

  always_comb begin
    state_nxt = state;
    take_a    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_nxt = ST_WAIT_A;
      ST_WAIT_A: take_a = rx_valid;
      ST_WAIT_B: begin
        if (rx_valid) begin
          case (byte_a.tag)
            TAG_WORD: state_nxt = ST_WRITE;
            TAG_ADDR: state_nxt = ST_WAIT_A;
            default:  state_nxt = ST_DONE;
          endcase
        end else if (tmo_expired) begin
          state_nxt = ST_WAIT_A;
        end
      end
      ST_WRITE: begin
        take_a    = rx_valid;
        state_nxt = ST_WAIT_A;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // WAIT_A and WRITE share the byte-A rules; an illegal tag aborts without waiting for B.
    if (take_a) state_nxt = tag_legal(rx_data[7:4]) ? ST_WAIT_B : ST_ERROR;
  end

  assign tmo_load = take_a && tag_legal(rx_data[7:4]);

  loader_timeout #(.W(TW)) u_timeout (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmo_load),
    .load_val (TW'(TIMEOUT - 1)),
    .en       (state == ST_WAIT_B),
    .expired  (tmo_expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      wr    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      wr    <= (state_nxt == ST_WRITE);
      busy  <= is_busy_state(state_nxt);
      done  <= (state_nxt == ST_DONE);
      err   <= (state_nxt == ST_ERROR);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_a     <= '0;
      addr       <= '0;
      data_out   <= '0;
      word_count <= '0;
    end else begin
      if (take_a) byte_a <= byte_a_t'(rx_data);
      if (!is_busy_state(state) && start) begin
        addr       <= '0;
        word_count <= '0;
      end else if (state == ST_WRITE) begin
        addr <= addr + 1'b1;
        if (word_count != COUNT_MAX) word_count <= word_count + 1'b1;
      end else if ((state == ST_WAIT_B) && rx_valid && (byte_a.tag == TAG_ADDR)) begin
        addr <= AW'({byte_a.hi[0], rx_data});
      end
      if ((state == ST_WAIT_B) && rx_valid && (byte_a.tag == TAG_WORD))
        data_out <= DW'({byte_a.hi, rx_data});
    end
  end

endmodule

// File: tb/tb_simplez_loader.sv
// Directed-vector bench for simplez_loader with a short timeout so the gap cases stay cheap.
module tb_simplez_loader;

  localparam int unsigned AW  = 9;
  localparam int unsigned DW  = 12;
  localparam int unsigned TMO = 40;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] addr;
  logic          wr;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];

  simplez_loader #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .addr       (addr),
    .wr         (wr),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // memory-side view: capture what a negedge-sampling RAM would store
  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wa_q.push_back(addr);
      wd_q.push_back(data_out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // all drivers assume they are called at a negedge and return at a negedge
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (idx < wa_q.size()) begin
      chk({tag, "_addr"}, 32'(wa_q[idx]), 32'(a));
      chk({tag, "_data"}, 32'(wd_q[idx]), 32'(d));
    end else begin
      chk({tag, "_present"}, 32'(wa_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    idle(3);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_wr", 32'(wr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_cnt", 32'(word_count), 32'h0);
    rstn = 1'b1;
    idle(2);

    // 1: two words at 0 and 1, then END
    clear_log();
    pulse_start();
    chk("t1_busy", 32'(busy), 32'h1);
    send(8'h11);
    send(8'h23);
    chk("t1_wr_lat", 32'(wr), 32'h1);
    chk("t1_addr_wr", 32'(addr), 32'h0);
    chk("t1_data_wr", 32'(data_out), 32'h123);
    idle(2);
    chk("t1_wr_one", 32'(wr), 32'h0);
    send(8'h12);
    send(8'h34);
    idle(2);
    send(8'hF0);
    chk("t1_busy_b", 32'(busy), 32'h1);
    send(8'h00);
    idle(2);
    chk("t1_nwr", 32'(wa_q.size()), 32'd2);
    chk_write("t1_w0", 0, 9'd0, 12'h123);
    chk_write("t1_w1", 1, 9'd1, 12'h234);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_busy_end", 32'(busy), 32'h0);
    chk("t1_cnt", 32'(word_count), 32'd2);
    chk("t1_addr", 32'(addr), 32'd2);

    // 2: ADDR to 511, WORD wraps address to 0
    clear_log();
    pulse_start();
    chk("t2_addr0", 32'(addr), 32'h0);
    chk("t2_done_clr", 32'(done), 32'h0);
    send(8'h23);
    send(8'hFF);
    chk("t2_addr_set", 32'(addr), 32'd511);
    send(8'h17);
    send(8'h77);
    send(8'hF0);
    send(8'h00);
    idle(2);
    chk("t2_nwr", 32'(wa_q.size()), 32'd1);
    chk_write("t2_w0", 0, 9'd511, 12'h777);
    chk("t2_addr_wrap", 32'(addr), 32'd0);
    chk("t2_cnt", 32'(word_count), 32'd1);
    chk("t2_done", 32'(done), 32'h1);

    // 3: illegal tag, ignored bytes while in ERROR, start clears err
    clear_log();
    pulse_start();
    send(8'h5A);
    chk("t3_err", 32'(err), 32'h1);
    chk("t3_busy", 32'(busy), 32'h0);
    send(8'h11);
    send(8'h11);
    idle(2);
    chk("t3_nwr", 32'(wa_q.size()), 32'd0);
    chk("t3_err_hold", 32'(err), 32'h1);
    chk("t3_data_keep", 32'(data_out), 32'h777);
    pulse_start();
    chk("t3_err_clr", 32'(err), 32'h0);
    chk("t3_busy_re", 32'(busy), 32'h1);
    send(8'hF0);
    send(8'h00);
    idle(1);
    chk("t3_done", 32'(done), 32'h1);

    // 4: byte A abandoned after exactly TMO idle cycles; a byte just inside the window still counts
    clear_log();
    pulse_start();
    send(8'h11);
    idle(TMO);
    chk("t4_busy_wait", 32'(busy), 32'h1);
    send(8'h12);
    send(8'h34);
    idle(2);
    chk("t4_nwr", 32'(wa_q.size()), 32'd1);
    chk_write("t4_w0", 0, 9'd0, 12'h234);
    send(8'h11);
    idle(TMO - 2);
    send(8'h34);
    idle(2);
    chk("t4_nwr_b", 32'(wa_q.size()), 32'd2);
    chk_write("t4_w1", 1, 9'd1, 12'h134);
    send(8'hF0);
    send(8'h00);
    idle(1);

    // 5: reset while waiting for byte B
    clear_log();
    pulse_start();
    send(8'h23);
    send(8'h05);
    chk("t5_addr_set", 32'(addr), 32'h105);
    send(8'h11);
    rstn = 1'b0;
    #1;
    chk("t5_rst_addr", 32'(addr), 32'h0);
    chk("t5_rst_data", 32'(data_out), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_done", 32'(done), 32'h0);
    chk("t5_rst_cnt", 32'(word_count), 32'h0);
    idle(2);
    rstn = 1'b1;
    send(8'h22);
    idle(2);
    chk("t5_nwr", 32'(wa_q.size()), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'h0);
    pulse_start();
    send(8'h17);
    send(8'h77);
    idle(1);
    chk_write("t5_w0", 0, 9'd0, 12'h777);
    send(8'hF0);
    send(8'h00);
    idle(1);

    // 6: back-to-back records, byte A arriving during the WRITE cycle
    clear_log();
    pulse_start();
    send(8'h11);
    send(8'hAA);
    send(8'h11);
    send(8'hBB);
    send(8'hF0);
    send(8'h00);
    idle(2);
    chk("t6_nwr", 32'(wa_q.size()), 32'd2);
    chk_write("t6_w0", 0, 9'd0, 12'h1AA);
    chk_write("t6_w1", 1, 9'd1, 12'h1BB);
    chk("t6_cnt", 32'(word_count), 32'd2);
    chk("t6_addr", 32'(addr), 32'd2);
    chk("t6_done", 32'(done), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
